// File: rtl/aes_128_arbiter.sv
// aes_128_arbiter: round-robin sharing of one pipelined aes_128 core between
// two requesters. Each issued operation carries a {valid, id} tag down a
// LATENCY-deep pipeline so the ciphertext returns to the requester that sent it.
// Optional statistics counters are compiled in with `define AES_ARB_STATS_EN.
module aes_128_arbiter #(
  parameter int LATENCY  = 21,
  parameter int NUM_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                req0_valid,
  input  logic                req1_valid,
  output logic                req0_ready,
  output logic                req1_ready,
  input  logic [NUM_BITS-1:0] req0_state,
  input  logic [NUM_BITS-1:0] req1_state,
  input  logic [NUM_BITS-1:0] req0_key,
  input  logic [NUM_BITS-1:0] req1_key,
  output logic [NUM_BITS-1:0] core_state,
  output logic [NUM_BITS-1:0] core_key,
  input  logic [NUM_BITS-1:0] core_out,
  output logic                res0_valid,
  output logic                res1_valid,
  output logic [NUM_BITS-1:0] res0_data,
  output logic [NUM_BITS-1:0] res1_data,
  output logic                busy
`ifdef AES_ARB_STATS_EN
  ,
  output logic [31:0]         issued0_cnt,
  output logic [31:0]         issued1_cnt,
  output logic [31:0]         retired_cnt
`endif
);

  // Requester id of the most recent transfer; 1 after reset so req0 wins the first tie.
  logic                last_grant_q;
  logic                grant0;
  logic                grant1;
  logic                xfer;
  logic                gid;
  logic [NUM_BITS-1:0] core_state_q;
  logic [NUM_BITS-1:0] core_key_q;
  logic [LATENCY-1:0]  tag_vld_q;
  logic [LATENCY-1:0]  tag_id_q;
  logic                res0_q;
  logic                res1_q;

  // Combinational round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && en) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  assign xfer       = grant0 | grant1;
  assign gid        = grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Round-robin history: remembers who was served on the latest transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (xfer) begin
      last_grant_q <= gid;
    end
  end

  // Core input registers: load the winner's state/key on a transfer, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_state_q <= '0;
      core_key_q   <= '0;
    end else if (xfer) begin
      core_state_q <= gid ? req1_state : req0_state;
      core_key_q   <= gid ? req1_key   : req0_key;
    end
  end

  assign core_state = core_state_q;
  assign core_key   = core_key_q;

  // Tag valid pipeline: shifts every edge; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[LATENCY-2:0], xfer};
    end
  end

  // Tag id pipeline: only meaningful alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_id_q <= {tag_id_q[LATENCY-2:0], gid};
  end

  // Retire: the tail tag is registered into the strobe of the owning requester,
  // lining up with the cycle the core presents that operation's ciphertext.
  always_ff @(posedge clk) begin
    if (rst) begin
      res0_q <= 1'b0;
      res1_q <= 1'b0;
    end else begin
      res0_q <= tag_vld_q[LATENCY-1] & ~tag_id_q[LATENCY-1];
      res1_q <= tag_vld_q[LATENCY-1] &  tag_id_q[LATENCY-1];
    end
  end

  assign res0_valid = res0_q;
  assign res1_valid = res1_q;
  assign res0_data  = core_out;
  assign res1_data  = core_out;
  assign busy       = |tag_vld_q;

`ifdef AES_ARB_STATS_EN
  logic [31:0] issued0_q;
  logic [31:0] issued1_q;
  logic [31:0] retired_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating activity counters for issued and retired operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued0_q <= '0;
      issued1_q <= '0;
      retired_q <= '0;
    end else begin
      if (grant0) issued0_q <= sat_inc(issued0_q);
      if (grant1) issued1_q <= sat_inc(issued1_q);
      if (res0_q || res1_q) retired_q <= sat_inc(retired_q);
    end
  end

  assign issued0_cnt = issued0_q;
  assign issued1_cnt = issued1_q;
  assign retired_cnt = retired_q;
`endif

endmodule

// File: doc/aes_128_arbiter.md
# aes_128_arbiter

Shares one fully pipelined `aes_128` core (one encryption accepted per cycle, fixed 21-cycle latency) between two independent requesters. Round-robin grant selects which requester's state/key pair enters the core each cycle. A tag pipeline tracks every issued operation so each ciphertext is steered back to the requester that issued it. Sits between the plaintext/key sources (LFSR generators or host logic) and the `aes_128` datapath.

## Interface
- `LATENCY`, 21, core latency in clk cycles from input capture to valid `out`
- `NUM_BITS`, 128, state/key/ciphertext width
- `clk` in 1: single clock, also drives the core
- `rst` in 1: synchronous, active-high
- `en` in 1: issue enable; 0 blocks new grants, in-flight operations still complete
- `req0_valid`, `req1_valid` in 1: request present
- `req0_ready`, `req1_ready` out 1: grant; transfer on valid&ready at rising edge
- `req0_state`, `req1_state` in NUM_BITS: plaintext
- `req0_key`, `req1_key` in NUM_BITS: key
- `core_state`, `core_key` out NUM_BITS: registered core inputs
- `core_out` in NUM_BITS: core ciphertext
- `res0_valid`, `res1_valid` out 1: result strobe, single cycle, no backpressure
- `res0_data`, `res1_data` out NUM_BITS: ciphertext; equals `core_out`, valid only with strobe
- `busy` out 1: any operation in flight

## Operation
- Arbitration: combinational grant from `en`, `req*_valid`, `last_grant` register.
  - Only one valid: that requester granted.
  - Both valid: requester != `last_grant` granted.
  - `en`=0 or `rst`=1: both ready low.
  - `last_grant` updates to granted id on every transfer; holds otherwise.
- Issue: on transfer, `core_state`/`core_key` load granted requester's state/key. No transfer: both hold previous values; no tag issued.
- Tag pipeline: LATENCY stages of {valid, id}. Stage 0 loads {transfer, granted id} each edge; stages shift every edge unconditionally.
- Retire: tail stage valid -> `res<id>_valid`=1, `res<id>_data`=`core_out`; other requester's strobe 0. Results leave in issue order.
- `busy` = OR of all tag valid bits.
- Requesters must consume results same cycle; no buffering.

## Timing
- Reset values: `core_state`, `core_key` 0; all tag stages invalid; `last_grant`=1 (requester 0 wins first tie); `res*_valid` 0; `busy` 0; ready low while `rst` high.
- Throughput: one transfer per cycle sustained; both requesters valid -> strict alternation 0,1,0,1...
- Latency: transfer at edge t -> matching `res*_valid` high in the cycle after edge t+LATENCY.
- Back-to-back transfers -> back-to-back strobes, no gaps.
- `en` deasserted mid-stream: grants stop immediately (same cycle, combinational); in-flight results still delivered; `busy` falls LATENCY edges after last transfer.
- Reset mid-operation: all tags cleared at the reset edge; in-flight results discarded, no strobe for them even though core keeps computing; `last_grant` returns to 1.
- Simultaneous retire and issue: independent, both occur.

## Configuration
- `AES_ARB_STATS_EN` defined: adds outputs `issued0_cnt`, `issued1_cnt`, `retired_cnt` (32-bit each, reset 0). Issued counters increment on their requester's transfer; `retired_cnt` increments on any result strobe. All saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; remaining behaviour identical.

## Test plan
- FIPS-197: req0 key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff, one transfer -> `res0_valid` exactly LATENCY cycles later, data 69c4e0d86a7b0430d8cdb78070b4c55a; `res1_valid` never asserts.
- Both requesters valid for 10 cycles with distinct LFSR-driven inputs -> grants alternate starting with req0; 5 results each; each matches reference model, in issue order, on correct port.
- Only req1 valid for 8 cycles -> req1 granted every cycle; 8 consecutive `res1_valid` strobes; `busy` drops LATENCY cycles after last transfer.
- `en` low for 3 cycles mid-stream with both valid -> no grants those cycles; round-robin resumes from saved `last_grant`; no results lost.
- Assert `rst` 5 cycles after 4 transfers -> zero result strobes afterwards; `busy`=0; next tie grants req0.
- With `AES_ARB_STATS_EN`: after 6 req0 and 4 req1 transfers fully retired -> counters 6, 4, 10; reset clears all to 0.
